// File: rtl/bus_commands.sv
// ============================================================================
//  Module      : bus_commands (package)
//  Description : Shared HP48 bus command encodings and arbiter state codes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_commands;

    localparam logic [3:0] BUS_CMD_NOP   = 4'h0;
    localparam logic [3:0] BUS_CMD_READ  = 4'h1;
    localparam logic [3:0] BUS_CMD_WRITE = 4'h2;

    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_XFER = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/hp48_bus_arbiter.sv
// ============================================================================
//  Module      : hp48_bus_arbiter
//  Description : Round-robin cpu/lcd arbiter issuing nibble bursts on the bus.
//                Define HP48_BUS_ARB_LCD_EN to enable the lcd read port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hp48_bus_arbiter
    import bus_commands::*;
#(
    parameter int LEN_W = 4
) (
    input  logic             strobe,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [19:0]      cpu_addr,
    input  logic [LEN_W-1:0] cpu_len,
    input  logic [3:0]       cpu_wdata,
    output logic             cpu_gnt,
    output logic             cpu_wready,
    output logic [3:0]       cpu_rdata,
    output logic             cpu_rvalid,
    output logic             cpu_done,
    output logic             cpu_err,
    input  logic             lcd_req,
    input  logic [19:0]      lcd_addr,
    input  logic [LEN_W-1:0] lcd_len,
    output logic             lcd_gnt,
    output logic [3:0]       lcd_rdata,
    output logic             lcd_rvalid,
    output logic             lcd_done,
    output logic             lcd_err,
    output logic [19:0]      bus_address,
    output logic [3:0]       bus_command,
    output logic [3:0]       bus_nibble_out,
    input  logic [3:0]       bus_nibble_in,
    input  logic             bus_error
);

    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_next_state;
    logic             r_owner_lcd;
    logic             r_lcd_next;
    logic             r_we;
    logic             r_err;
    logic             r_rvalid;
    logic [19:0]      r_addr;
    logic [LEN_W-1:0] r_cnt;
    logic [3:0]       r_cpu_rdata;
    logic [3:0]       r_lcd_rdata;
    logic             w_lcd_req;
    logic             w_any_req;
    logic             w_pick_lcd;
    logic             w_last;

`ifdef HP48_BUS_ARB_LCD_EN
    assign w_lcd_req = lcd_req;
`else
    logic w_unused_lcd_req;
    assign w_unused_lcd_req = lcd_req;
    assign w_lcd_req        = 1'b0;
`endif

    assign w_any_req  = cpu_req | w_lcd_req;
    // lcd wins when alone, or on a conflict when it is lcd's turn
    assign w_pick_lcd = w_lcd_req & (~cpu_req | r_lcd_next);
    assign w_last     = (r_cnt == '0) | bus_error;

    always_ff @(posedge strobe or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req) w_next_state = ST_XFER;
            ST_XFER: if (w_last)    w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge strobe or negedge reset) begin
        if (!reset) begin
            r_owner_lcd <= 1'b0;
            r_lcd_next  <= 1'b1;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_rvalid    <= 1'b0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_cpu_rdata <= '0;
            r_lcd_rdata <= '0;
        end else begin
            r_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner_lcd <= w_pick_lcd;
                        r_lcd_next  <= ~w_pick_lcd;
                        r_we        <= ~w_pick_lcd & cpu_we;
                        r_addr      <= w_pick_lcd ? lcd_addr : cpu_addr;
                        r_cnt       <= w_pick_lcd ? lcd_len : cpu_len;
                        r_err       <= 1'b0;
                    end
                end
                ST_XFER: begin
                    if (bus_error) begin
                        r_err <= 1'b1;
                    end else begin
                        if (!r_we) begin
                            r_rvalid <= 1'b1;
                            if (r_owner_lcd) r_lcd_rdata <= bus_nibble_in;
                            else             r_cpu_rdata <= bus_nibble_in;
                        end
                        // address stops on the last nibble so the bus keeps showing it
                        if (r_cnt != '0) begin
                            r_addr <= r_addr + 20'd1;
                            r_cnt  <= r_cnt - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus_address = r_addr;
    assign cpu_rdata   = r_cpu_rdata;
    assign lcd_rdata   = r_lcd_rdata;
    assign cpu_rvalid  = r_rvalid & ~r_owner_lcd;
    assign lcd_rvalid  = r_rvalid &  r_owner_lcd;

    always_comb begin
        bus_command    = BUS_CMD_NOP;
        bus_nibble_out = 4'h0;
        cpu_wready     = 1'b0;
        cpu_gnt        = 1'b0;
        lcd_gnt        = 1'b0;
        cpu_done       = 1'b0;
        lcd_done       = 1'b0;
        cpu_err        = 1'b0;
        lcd_err        = 1'b0;
        case (r_state)
            ST_XFER: begin
                cpu_gnt     = ~r_owner_lcd;
                lcd_gnt     =  r_owner_lcd;
                bus_command = r_we ? BUS_CMD_WRITE : BUS_CMD_READ;
                if (r_we) begin
                    cpu_wready     = 1'b1;
                    bus_nibble_out = cpu_wdata;
                end
            end
            ST_DONE: begin
                cpu_gnt  = ~r_owner_lcd;
                lcd_gnt  =  r_owner_lcd;
                cpu_done = ~r_owner_lcd;
                lcd_done =  r_owner_lcd;
                cpu_err  = ~r_owner_lcd & r_err;
                lcd_err  =  r_owner_lcd & r_err;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_hp48_bus_arbiter.sv
// ============================================================================
//  Module      : tb_hp48_bus_arbiter
//  Description : Directed self-checking bench for hp48_bus_arbiter.
//                Follows HP48_BUS_ARB_LCD_EN to pick the lcd scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hp48_bus_arbiter;
    import bus_commands::*;

    localparam int LEN_W = 4;

    logic             strobe = 1'b0;
    logic             reset  = 1'b0;
    logic             cpu_req = 1'b0, cpu_we = 1'b0;
    logic [19:0]      cpu_addr = '0;
    logic [LEN_W-1:0] cpu_len = '0;
    logic [3:0]       cpu_wdata = '0;
    logic             cpu_gnt, cpu_wready, cpu_rvalid, cpu_done, cpu_err;
    logic [3:0]       cpu_rdata;
    logic             lcd_req = 1'b0;
    logic [19:0]      lcd_addr = '0;
    logic [LEN_W-1:0] lcd_len = '0;
    logic             lcd_gnt, lcd_rvalid, lcd_done, lcd_err;
    logic [3:0]       lcd_rdata;
    logic [19:0]      bus_address;
    logic [3:0]       bus_command, bus_nibble_out;
    logic [3:0]       bus_nibble_in = '0;
    logic             bus_error = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 strobe = ~strobe;

    hp48_bus_arbiter #(.LEN_W(LEN_W)) dut (
        .strobe(strobe), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_len(cpu_len),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_wready(cpu_wready),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_done(cpu_done), .cpu_err(cpu_err),
        .lcd_req(lcd_req), .lcd_addr(lcd_addr), .lcd_len(lcd_len), .lcd_gnt(lcd_gnt),
        .lcd_rdata(lcd_rdata), .lcd_rvalid(lcd_rvalid), .lcd_done(lcd_done), .lcd_err(lcd_err),
        .bus_address(bus_address), .bus_command(bus_command), .bus_nibble_out(bus_nibble_out),
        .bus_nibble_in(bus_nibble_in), .bus_error(bus_error)
    );

    // Memory contents seen on the bus for a given address
    function automatic logic [3:0] mem_nib(input logic [19:0] a);
        return a[3:0] ^ a[11:8] ^ 4'h5;
    endfunction

    task automatic tick;
        @(posedge strobe);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #3;
        n_checks++;
        if ({cpu_gnt, lcd_gnt, cpu_wready, cpu_rvalid, lcd_rvalid, cpu_done, lcd_done, cpu_err, lcd_err} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000000000",
                     {cpu_gnt, lcd_gnt, cpu_wready, cpu_rvalid, lcd_rvalid, cpu_done, lcd_done, cpu_err, lcd_err});
        end
        n_checks++;
        if (bus_command !== BUS_CMD_NOP || bus_address !== 20'h0 || bus_nibble_out !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got cmd=%h addr=%h nib=%h want %h/00000/0",
                     bus_command, bus_address, bus_nibble_out, BUS_CMD_NOP);
        end
        n_checks++;
        if (cpu_rdata !== 4'h0 || lcd_rdata !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got cpu=%h lcd=%h want 0/0", cpu_rdata, lcd_rdata);
        end
        tick;
        tick;
        reset = 1'b1;
        tick;
        n_checks++;
        if (cpu_gnt !== 1'b0 || bus_command !== BUS_CMD_NOP) begin
            n_fail++;
            $display("FAIL idle_no_req: got gnt=%b cmd=%h want 0/%h", cpu_gnt, bus_command, BUS_CMD_NOP);
        end
    endtask

    task automatic test_cpu_read;
        logic [19:0] a;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00100; cpu_len = 4'd3;
        #1;
        n_checks++;
        if (cpu_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_gnt_early: got %b want 0", cpu_gnt);
        end
        tick;
        cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 20'h00100 + 20'(i);
            bus_nibble_in = mem_nib(a);
            #1;
            n_checks++;
            if (cpu_gnt !== 1'b1 || bus_command !== BUS_CMD_READ || bus_address !== a) begin
                n_fail++;
                $display("FAIL rd_xfer[%0d]: got gnt=%b cmd=%h addr=%h want 1/%h/%h",
                         i, cpu_gnt, bus_command, bus_address, BUS_CMD_READ, a);
            end
            n_checks++;
            if (cpu_rvalid !== 1'(i != 0)) begin
                n_fail++;
                $display("FAIL rd_rvalid[%0d]: got %b want %b", i, cpu_rvalid, 1'(i != 0));
            end
            if (i != 0) begin
                n_checks++;
                if (cpu_rdata !== mem_nib(a - 20'd1)) begin
                    n_fail++;
                    $display("FAIL rd_data[%0d]: got %h want %h", i, cpu_rdata, mem_nib(a - 20'd1));
                end
            end
            tick;
        end
        n_checks++;
        if (cpu_done !== 1'b1 || cpu_err !== 1'b0 || cpu_gnt !== 1'b1 || cpu_rvalid !== 1'b1 ||
            cpu_rdata !== mem_nib(20'h00103) || bus_command !== BUS_CMD_NOP) begin
            n_fail++;
            $display("FAIL rd_done: got done=%b err=%b gnt=%b rv=%b rd=%h cmd=%h want 1/0/1/1/%h/%h",
                     cpu_done, cpu_err, cpu_gnt, cpu_rvalid, cpu_rdata, bus_command,
                     mem_nib(20'h00103), BUS_CMD_NOP);
        end
        tick;
        n_checks++;
        if (cpu_done !== 1'b0 || cpu_gnt !== 1'b0 || cpu_rvalid !== 1'b0 || bus_address !== 20'h00103) begin
            n_fail++;
            $display("FAIL rd_idle: got done=%b gnt=%b rv=%b addr=%h want 0/0/0/00103",
                     cpu_done, cpu_gnt, cpu_rvalid, bus_address);
        end
    endtask

    task automatic test_cpu_write;
        logic [19:0] a;
        logic [3:0]  wd [3];
        wd[0] = 4'hA; wd[1] = 4'hB; wd[2] = 4'hC;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h0FFFE; cpu_len = 4'd2;
        tick;
        cpu_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 20'h0FFFE + 20'(i);
            cpu_wdata = wd[i];
            #1;
            n_checks++;
            if (bus_command !== BUS_CMD_WRITE || bus_address !== a || bus_nibble_out !== wd[i] ||
                cpu_wready !== 1'b1 || cpu_rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_xfer[%0d]: got cmd=%h addr=%h nib=%h wr=%b rv=%b want %h/%h/%h/1/0",
                         i, bus_command, bus_address, bus_nibble_out, cpu_wready, cpu_rvalid,
                         BUS_CMD_WRITE, a, wd[i]);
            end
            tick;
        end
        n_checks++;
        if (cpu_done !== 1'b1 || cpu_err !== 1'b0 || cpu_wready !== 1'b0 || bus_nibble_out !== 4'h0) begin
            n_fail++;
            $display("FAIL wr_done: got done=%b err=%b wr=%b nib=%h want 1/0/0/0",
                     cpu_done, cpu_err, cpu_wready, bus_nibble_out);
        end
        tick;
        cpu_we = 1'b0;
        n_checks++;
        if (bus_address !== 20'h10000 || bus_command !== BUS_CMD_NOP) begin
            n_fail++;
            $display("FAIL wr_idle: got addr=%h cmd=%h want 10000/%h", bus_address, bus_command, BUS_CMD_NOP);
        end
    endtask

`ifdef HP48_BUS_ARB_LCD_EN
    task automatic test_round_robin;
        logic        exp_lcd;
        logic [19:0] a;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 20'h00300; cpu_len = 4'd0;
        lcd_addr = 20'h20000; lcd_len = 4'd0;
        cpu_req = 1'b1; lcd_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_lcd = (k != 1);
            a = exp_lcd ? 20'h20000 : 20'h00300;
            tick;
            bus_nibble_in = mem_nib(a);
            #1;
            n_checks++;
            if (lcd_gnt !== exp_lcd || cpu_gnt !== !exp_lcd || bus_address !== a) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: got lcd=%b cpu=%b addr=%h want %b/%b/%h",
                         k, lcd_gnt, cpu_gnt, bus_address, exp_lcd, !exp_lcd, a);
            end
            tick;
            n_checks++;
            if (lcd_done !== exp_lcd || cpu_done !== !exp_lcd || lcd_rvalid !== exp_lcd ||
                cpu_rvalid !== !exp_lcd || (exp_lcd ? lcd_rdata : cpu_rdata) !== mem_nib(a)) begin
                n_fail++;
                $display("FAIL rr_done[%0d]: got ld=%b cd=%b lv=%b cv=%b lr=%h cr=%h want owner lcd=%b data %h",
                         k, lcd_done, cpu_done, lcd_rvalid, cpu_rvalid, lcd_rdata, cpu_rdata, exp_lcd, mem_nib(a));
            end
            tick;
            n_checks++;
            if (lcd_gnt !== 1'b0 || cpu_gnt !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_gap[%0d]: got lcd=%b cpu=%b want 0/0", k, lcd_gnt, cpu_gnt);
            end
        end
        cpu_req = 1'b0; lcd_req = 1'b0;
        tick;
        tick;
    endtask
`else
    task automatic test_lcd_disabled;
        lcd_req = 1'b1; lcd_addr = 20'h20000; lcd_len = 4'd0;
        tick;
        n_checks++;
        if (lcd_gnt !== 1'b0 || bus_command !== BUS_CMD_NOP) begin
            n_fail++;
            $display("FAIL dis_lcd_only: got gnt=%b cmd=%h want 0/%h", lcd_gnt, bus_command, BUS_CMD_NOP);
        end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00400; cpu_len = 4'd1;
        tick;
        cpu_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (lcd_gnt !== 1'b0 || cpu_gnt !== 1'b1 || bus_address !== 20'h00400 + 20'(i)) begin
                n_fail++;
                $display("FAIL dis_xfer[%0d]: got lcd=%b cpu=%b addr=%h want 0/1/%h",
                         i, lcd_gnt, cpu_gnt, bus_address, 20'h00400 + 20'(i));
            end
            tick;
        end
        n_checks++;
        if (cpu_done !== 1'b1 || {lcd_gnt, lcd_done, lcd_rvalid, lcd_err} !== 4'b0 || lcd_rdata !== 4'h0) begin
            n_fail++;
            $display("FAIL dis_done: got cd=%b lcd=%b rd=%h want 1/0000/0",
                     cpu_done, {lcd_gnt, lcd_done, lcd_rvalid, lcd_err}, lcd_rdata);
        end
        lcd_req = 1'b0;
        tick;
    endtask
`endif

    task automatic test_bus_error;
        int rv;
        int busy;
        rv = 0;
        busy = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00500; cpu_len = 4'd7;
        tick;
        cpu_req = 1'b0;
        bus_nibble_in = mem_nib(20'h00500);
        #1;
        rv += int'(cpu_rvalid);
        tick;
        bus_nibble_in = mem_nib(20'h00501);
        bus_error = 1'b1;
        #1;
        rv += int'(cpu_rvalid);
        n_checks++;
        if (bus_command !== BUS_CMD_READ || bus_address !== 20'h00501) begin
            n_fail++;
            $display("FAIL err_xfer2: got cmd=%h addr=%h want %h/00501", bus_command, bus_address, BUS_CMD_READ);
        end
        tick;
        bus_error = 1'b0;
        rv += int'(cpu_rvalid);
        n_checks++;
        if (cpu_done !== 1'b1 || cpu_err !== 1'b1 || cpu_rvalid !== 1'b0 || cpu_rdata !== mem_nib(20'h00500)) begin
            n_fail++;
            $display("FAIL err_done: got done=%b err=%b rv=%b rd=%h want 1/1/0/%h",
                     cpu_done, cpu_err, cpu_rvalid, cpu_rdata, mem_nib(20'h00500));
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            rv += int'(cpu_rvalid);
            if (bus_command !== BUS_CMD_NOP || cpu_err !== 1'b0) busy++;
        end
        n_checks++;
        if (busy !== 0) begin
            n_fail++;
            $display("FAIL err_after: got %0d busy cycles want 0", busy);
        end
        n_checks++;
        if (rv !== 1) begin
            n_fail++;
            $display("FAIL err_rvalid_count: got %0d want 1", rv);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        seen = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00700; cpu_len = 4'd5;
        tick;
        for (int i = 0; i < 2; i++) begin
            bus_nibble_in = mem_nib(20'h00700 + 20'(i));
            tick;
        end
        #1;
        n_checks++;
        if (bus_command !== BUS_CMD_READ || bus_address !== 20'h00702 || cpu_rdata !== mem_nib(20'h00701)) begin
            n_fail++;
            $display("FAIL rst_pre: got cmd=%h addr=%h rd=%h want %h/00702/%h",
                     bus_command, bus_address, cpu_rdata, BUS_CMD_READ, mem_nib(20'h00701));
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({cpu_gnt, cpu_rvalid, cpu_done, cpu_err} !== 4'b0 || bus_command !== BUS_CMD_NOP ||
            bus_address !== 20'h0 || cpu_rdata !== 4'h0) begin
            n_fail++;
            $display("FAIL rst_mid: got flags=%b cmd=%h addr=%h rd=%h want 0000/%h/00000/0",
                     {cpu_gnt, cpu_rvalid, cpu_done, cpu_err}, bus_command, bus_address, cpu_rdata, BUS_CMD_NOP);
        end
        cpu_req = 1'b0;
        tick;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            seen += int'(cpu_done | cpu_gnt);
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL rst_wait: got %0d active cycles want 0", seen);
        end
        cpu_req = 1'b1; cpu_addr = 20'hFFFFF; cpu_len = 4'd1;
        tick;
        cpu_req = 1'b0;
        bus_nibble_in = mem_nib(20'hFFFFF);
        #1;
        n_checks++;
        if (bus_address !== 20'hFFFFF || bus_command !== BUS_CMD_READ) begin
            n_fail++;
            $display("FAIL wrap_0: got addr=%h cmd=%h want FFFFF/%h", bus_address, bus_command, BUS_CMD_READ);
        end
        tick;
        bus_nibble_in = mem_nib(20'h00000);
        #1;
        n_checks++;
        if (bus_address !== 20'h00000 || bus_command !== BUS_CMD_READ) begin
            n_fail++;
            $display("FAIL wrap_1: got addr=%h cmd=%h want 00000/%h", bus_address, bus_command, BUS_CMD_READ);
        end
        tick;
        n_checks++;
        if (cpu_done !== 1'b1 || cpu_rdata !== mem_nib(20'h00000)) begin
            n_fail++;
            $display("FAIL wrap_done: got done=%b rd=%h want 1/%h", cpu_done, cpu_rdata, mem_nib(20'h00000));
        end
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want end of test");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset;
        test_cpu_read;
        test_cpu_write;
`ifdef HP48_BUS_ARB_LCD_EN
        test_round_robin;
`else
        test_lcd_disabled;
`endif
        test_bus_error;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
